// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: shared definitions for the CPU execution unit.
//   - opcode values (must match the control unit's opcode field)
//   - FSM state encoding
//   - iteration count of the multiply/divide engine
package cpu_alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'd8;
  localparam logic [OP_W-1:0] OP_SUB = 6'd9;
  localparam logic [OP_W-1:0] OP_LSR = 6'd10;
  localparam logic [OP_W-1:0] OP_LSL = 6'd11;
  localparam logic [OP_W-1:0] OP_RSR = 6'd12;
  localparam logic [OP_W-1:0] OP_RSL = 6'd13;
  localparam logic [OP_W-1:0] OP_MUL = 6'd14;
  localparam logic [OP_W-1:0] OP_DIV = 6'd15;
  localparam logic [OP_W-1:0] OP_MOD = 6'd16;
  localparam logic [OP_W-1:0] OP_AND = 6'd17;
  localparam logic [OP_W-1:0] OP_OR  = 6'd18;
  localparam logic [OP_W-1:0] OP_XOR = 6'd19;
  localparam logic [OP_W-1:0] OP_NOT = 6'd20;
  localparam logic [OP_W-1:0] OP_CMP = 6'd21;
  localparam logic [OP_W-1:0] OP_TST = 6'd22;
  localparam logic [OP_W-1:0] OP_INC = 6'd23;
  localparam logic [OP_W-1:0] OP_DEC = 6'd24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int ITER_STEPS = 16;

  // Division by zero is resolved without iterating; MUL always iterates.
  function automatic logic is_iter_op(input logic [OP_W-1:0] op, input logic [15:0] divisor);
    return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (divisor != 16'd0));
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared 16-step engine for unsigned multiply (LSB-first
// shift-add) and unsigned restoring division.
//   clk_i, rst_b_i  : clock / async active-low reset (control state only)
//   start_i         : load operands; steps follow on the next 16 edges
//   div_i           : 1 = divide a_i by b_i, 0 = multiply a_i * b_i
//   a_i, b_i        : operands, sampled with start_i
//   done_o          : high once all steps are complete, until the next edge
//   hi_o, lo_o      : MUL -> product high/low; DIV/MOD -> remainder/quotient
module alu_muldiv_iter
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [4:0] LAST = 5'(ITER_STEPS);

  logic             run_q;
  logic [4:0]       cnt_q;
  logic             div_q;
  logic [WIDTH-1:0] m_q, hi_q, lo_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             step;

  assign step   = run_q && (cnt_q != LAST);
  assign done_o = run_q && (cnt_q == LAST);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
    end else if (done_o) begin
      run_q <= 1'b0;
    end else if (step) begin
      cnt_q <= cnt_q + 5'd1;
    end
  end

  // hi/lo double as partial-product/multiplier for MUL and
  // partial-remainder/quotient for DIV; m holds multiplicand or divisor.
  always_comb begin
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rs;
    sum  = '0;
    rs   = '0;
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_q) begin
      rs = {hi_q, lo_q[WIDTH-1]};
      if (rs >= {1'b0, m_q}) begin
        sum  = rs - {1'b0, m_q};
        hi_d = sum[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = rs[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i) begin
      div_q <= div_i;
      m_q   <= div_i ? b_i : a_i;
      lo_q  <= div_i ? a_i : b_i;
      hi_q  <= '0;
    end else if (step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/cpu_alu.sv
// cpu_alu: execution unit downstream of the control unit.
//   clk, rst_b          : clock / async active-low reset
//   opcode, term1/term2 : operation and operands, sampled with alu_enable
//   alu_enable          : start request, honoured only while idle
//   alu_out             : registered result, held until the next completion
//   alu_done            : one-cycle completion pulse
//   alu_wb              : with alu_done, 1 = write alu_out to acc
//   alu_busy            : operation in flight
//   fl_*                : registered zero/negative/carry/overflow flags
module cpu_alu
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 6
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] term1,
  input  logic [WIDTH-1:0] term2,
  input  logic             alu_enable,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_done,
  output logic             alu_wb,
  output logic             alu_busy,
  output logic             fl_zero,
  output logic             fl_negative,
  output logic             fl_carry,
  output logic             fl_overflow
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] out_q;
  logic             done_q, wb_q, z_q, n_q, c_q, v_q;

  logic             accept, iter_op, eng_start, eng_done;
  logic [WIDTH-1:0] eng_hi, eng_lo;
  logic [WIDTH-1:0] operand_b;
  logic [3:0]       shamt;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v, res_wb, res_upd;

  // The done cycle itself is not an acceptance slot; the next request
  // is taken in the cycle after the pulse.
  assign accept    = (state_q == ST_IDLE) && !done_q && alu_enable;
  assign iter_op   = is_iter_op(opcode, term2);
  assign eng_start = accept && iter_op;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i   (clk),
    .rst_b_i (rst_b),
    .start_i (eng_start),
    .div_i   (opcode != OP_MUL),
    .a_i     (term1),
    .b_i     (term2),
    .done_o  (eng_done),
    .hi_o    (eng_hi),
    .lo_o    (eng_lo)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = iter_op ? ST_ITER : ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_ITER: if (eng_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= opcode;
      a_q  <= term1;
      b_q  <= term2;
    end
  end

  assign operand_b = ((op_q == OP_INC) || (op_q == OP_DEC)) ? WIDTH'(1) : b_q;
  assign shamt     = b_q[3:0];

  // Result and carry/overflow for the latched operation. Unknown opcodes
  // keep the current outputs and flags.
  always_comb begin
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH:0]     ext;
    wide    = '0;
    ext     = '0;
    res     = out_q;
    res_c   = c_q;
    res_v   = v_q;
    res_wb  = 1'b0;
    res_upd = 1'b1;
    case (op_q)
      OP_ADD, OP_INC: begin
        ext    = {1'b0, a_q} + {1'b0, operand_b};
        res    = ext[WIDTH-1:0];
        res_c  = ext[WIDTH];
        res_v  = (a_q[WIDTH-1] == operand_b[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
        res_wb = 1'b1;
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        ext    = {1'b0, a_q} - {1'b0, operand_b};   // bit WIDTH is the borrow
        res    = ext[WIDTH-1:0];
        res_c  = ext[WIDTH];
        res_v  = (a_q[WIDTH-1] != operand_b[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
        res_wb = (op_q != OP_CMP);
      end
      OP_LSR: begin
        wide   = {a_q, {WIDTH{1'b0}}} >> shamt;
        res    = wide[2*WIDTH-1:WIDTH];
        res_c  = wide[WIDTH-1];
        res_v  = 1'b0;
        res_wb = 1'b1;
      end
      OP_LSL: begin
        wide   = {{WIDTH{1'b0}}, a_q} << shamt;
        res    = wide[WIDTH-1:0];
        res_c  = wide[WIDTH];
        res_v  = 1'b0;
        res_wb = 1'b1;
      end
      OP_RSR: begin
        wide   = {a_q, a_q} >> shamt;
        res    = wide[WIDTH-1:0];
        res_c  = (shamt != 4'd0) && res[WIDTH-1];  // last bit out lands in the MSB
        res_v  = 1'b0;
        res_wb = 1'b1;
      end
      OP_RSL: begin
        wide   = {a_q, a_q} << shamt;
        res    = wide[2*WIDTH-1:WIDTH];
        res_c  = (shamt != 4'd0) && res[0];        // last bit out lands in the LSB
        res_v  = 1'b0;
        res_wb = 1'b1;
      end
      OP_MUL: begin
        res    = eng_lo;
        res_c  = |eng_hi;
        res_v  = |eng_hi;
        res_wb = 1'b1;
      end
      OP_DIV: begin
        res    = (b_q == '0) ? '1 : eng_lo;
        res_c  = 1'b0;
        res_v  = (b_q == '0);
        res_wb = 1'b1;
      end
      OP_MOD: begin
        res    = (b_q == '0) ? a_q : eng_hi;
        res_c  = 1'b0;
        res_v  = (b_q == '0);
        res_wb = 1'b1;
      end
      OP_AND, OP_TST, OP_OR, OP_XOR, OP_NOT: begin
        case (op_q)
          OP_OR:   res = a_q | b_q;
          OP_XOR:  res = a_q ^ b_q;
          OP_NOT:  res = ~a_q;
          default: res = a_q & b_q;
        endcase
        res_c  = 1'b0;
        res_v  = 1'b0;
        res_wb = (op_q != OP_TST);
      end
      default: res_upd = 1'b0;
    endcase
  end

  // Outputs change only on the edge that leaves DONE, so the done pulse,
  // result and flags all appear together in the following cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_q  <= '0;
      done_q <= 1'b0;
      wb_q   <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        wb_q <= res_wb;
        if (res_upd) begin
          out_q <= res;
          z_q   <= (res == '0);
          n_q   <= res[WIDTH-1];
          c_q   <= res_c;
          v_q   <= res_v;
        end
      end
    end
  end

  assign alu_out     = out_q;
  assign alu_done    = done_q;
  assign alu_wb      = wb_q;
  assign alu_busy    = (state_q != ST_IDLE);
  assign fl_zero     = z_q;
  assign fl_negative = n_q;
  assign fl_carry    = c_q;
  assign fl_overflow = v_q;

endmodule

// File: tb/tb_cpu_alu.sv
module tb_cpu_alu;

  localparam logic [5:0] ADD = 6'd8,  SUB = 6'd9,  LSR = 6'd10, LSL = 6'd11;
  localparam logic [5:0] RSR = 6'd12, RSL = 6'd13, MUL = 6'd14, DIV = 6'd15;
  localparam logic [5:0] MOD = 6'd16, AND = 6'd17, ORR = 6'd18, XOR = 6'd19;
  localparam logic [5:0] NOT = 6'd20, CMP = 6'd21, TST = 6'd22, INC = 6'd23;
  localparam logic [5:0] DEC = 6'd24;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [5:0]  opcode;
  logic [15:0] term1, term2;
  logic        alu_enable;
  logic [15:0] alu_out;
  logic        alu_done, alu_wb, alu_busy;
  logic        fl_zero, fl_negative, fl_carry, fl_overflow;

  cpu_alu dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .opcode      (opcode),
    .term1       (term1),
    .term2       (term2),
    .alu_enable  (alu_enable),
    .alu_out     (alu_out),
    .alu_done    (alu_done),
    .alu_wb      (alu_wb),
    .alu_busy    (alu_busy),
    .fl_zero     (fl_zero),
    .fl_negative (fl_negative),
    .fl_carry    (fl_carry),
    .fl_overflow (fl_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] out;
    logic        z, n, c, v, wb;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] held_out = '0;
  logic [3:0]  held_fl  = '0;   // {z, n, c, v}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: what the unit must return, from plain integer arithmetic.
  function automatic exp_t model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int unsigned ua, ub, p;
    int          sa, sb, s;
    logic [15:0] r;
    logic        c, v, wb, known;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = '0; c = 0; v = 0; wb = 1; known = 1; e = '0; e.lat = 2;
    if (op == INC) begin ub = 1; sb = 1; end
    if (op == DEC) begin ub = 1; sb = 1; end
    case (op)
      ADD, INC: begin
        p = ua + ub; s = sa + sb;
        r = p[15:0]; c = (p > 65535); v = (s > 32767) || (s < -32768);
      end
      SUB, DEC, CMP: begin
        p = ua - ub; s = sa - sb;
        r = p[15:0]; c = (ua < ub); v = (s > 32767) || (s < -32768);
        wb = (op != CMP);
      end
      LSR, LSL, RSR, RSL: begin
        r = a;
        for (int i = 0; i < int'(b[3:0]); i++) begin
          case (op)
            LSR:     begin c = r[0];  r = r >> 1; end
            LSL:     begin c = r[15]; r = r << 1; end
            RSR:     begin c = r[0];  r = {r[0], r[15:1]}; end
            default: begin c = r[15]; r = {r[14:0], r[15]}; end
          endcase
        end
      end
      MUL: begin p = ua * ub; r = p[15:0]; c = (p > 65535); v = c; e.lat = 18; end
      DIV: if (ub == 0) begin r = 16'hFFFF; v = 1; end
           else begin p = ua / ub; r = p[15:0]; e.lat = 18; end
      MOD: if (ub == 0) begin r = a; v = 1; end
           else begin p = ua % ub; r = p[15:0]; e.lat = 18; end
      AND, TST: begin r = a & b; wb = (op != TST); end
      ORR: r = a | b;
      XOR: r = a ^ b;
      NOT: r = ~a;
      default: known = 0;
    endcase
    if (known) begin
      e.out = r; e.z = (r == 0); e.n = r[15]; e.c = c; e.v = v; e.wb = wb;
    end else begin
      e.out = held_out; {e.z, e.n, e.c, e.v} = held_fl; e.wb = 0;
    end
    return e;
  endfunction

  // Compare process: every cycle out of reset, outputs either carry the
  // expected completion or hold the last completed values.
  always @(negedge clk) begin
    if (rst_b) begin
      if (alu_done) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("alu_out", alu_out, e.out);
          chk("flags_znc_v", {fl_zero, fl_negative, fl_carry, fl_overflow}, {e.z, e.n, e.c, e.v});
          chk("alu_wb", alu_wb, e.wb);
          held_out = e.out;
          held_fl  = {e.z, e.n, e.c, e.v};
        end
      end else begin
        chk("hold_out", alu_out, held_out);
        chk("hold_flags", {fl_zero, fl_negative, fl_carry, fl_overflow}, held_fl);
        chk("busy", alu_busy, q.size() != 0);
      end
    end
  end

  task automatic start_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    @(negedge clk);
    opcode = op; term1 = a; term2 = b; alu_enable = 1'b1;
    e = model(op, a, b);
    @(posedge clk);
    #1;
    alu_enable = 1'b0;
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
  endtask

  // Pins the model to hand-computed values, then runs the op on the DUT.
  task automatic directed(input string name, input logic [5:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] r, input logic [4:0] znvcw,
                          input int lat);
    exp_t m;
    m = model(op, a, b);
    chk(name, {m.out, m.z, m.n, m.c, m.v, m.wb, 8'(m.lat)}, {r, znvcw, 8'(lat)});
    start_op(op, a, b);
    wait_idle();
  endtask

  logic [5:0] ops[21] = '{ADD, SUB, LSR, LSL, RSR, RSL, MUL, DIV, MOD, AND, ORR,
                          XOR, NOT, CMP, TST, INC, DEC, 6'd63, 6'd0, 6'd7, 6'd25};

  initial begin
    rst_b = 1'b0; opcode = '0; term1 = '0; term2 = '0; alu_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", alu_out, 0);
    chk("reset_ctl", {alu_done, alu_wb, alu_busy}, 0);
    chk("reset_flags", {fl_zero, fl_negative, fl_carry, fl_overflow}, 0);
    @(negedge clk) rst_b = 1'b1;

    //                                 out      z n c v wb   lat
    directed("add_ovf",  ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b01011, 2);
    directed("sub_zero", SUB, 16'h0005, 16'h0005, 16'h0000, 5'b10001, 2);
    directed("cmp_lt",   CMP, 16'h0003, 16'h0004, 16'hFFFF, 5'b01100, 2);
    directed("div",      DIV, 16'd1000, 16'd7,    16'h008E, 5'b00001, 18);
    directed("mod",      MOD, 16'd1000, 16'd7,    16'h0006, 5'b00001, 18);
    directed("div0",     DIV, 16'h1234, 16'h0000, 16'hFFFF, 5'b01011, 2);
    directed("mod0",     MOD, 16'h1234, 16'h0000, 16'h1234, 5'b00011, 2);
    directed("rsl1",     RSL, 16'h8001, 16'h0001, 16'h0003, 5'b00101, 2);
    directed("lsr0",     LSR, 16'h00F0, 16'h0000, 16'h00F0, 5'b00001, 2);
    directed("unknown",  6'd63, 16'hAAAA, 16'h5555, 16'h00F0, 5'b00000, 2);

    // MUL with a second enable pulsed mid-iteration: only one done.
    begin
      exp_t m;
      m = model(MUL, 16'd300, 16'd300);
      chk("mul_model", {m.out, m.z, m.n, m.c, m.v, m.wb, 8'(m.lat)}, {16'h5F90, 5'b00111, 8'd18});
    end
    start_op(MUL, 16'd300, 16'd300);
    repeat (5) @(posedge clk);
    @(negedge clk);
    opcode = ADD; term1 = 16'h1111; term2 = 16'h2222; alu_enable = 1'b1;
    @(negedge clk);
    alu_enable = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);

    for (int k = 0; k < 150; k++) begin
      logic [15:0] a, b;
      int          sel;
      a   = 16'($urandom);
      sel = $urandom_range(0, 5);
      if (sel == 0)      b = '0;
      else if (sel == 1) b = 16'($urandom_range(0, 15));
      else               b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h7FFF + 16'($urandom_range(0, 2));
      start_op(ops[$urandom_range(0, 20)], a, b);
      wait_idle();
    end

    // Reset during MUL iteration step 8.
    start_op(MUL, 16'd300, 16'd300);
    repeat (8) @(posedge clk);
    #3;
    rst_b = 1'b0;
    q.delete();
    held_out = '0;
    held_fl  = '0;
    #1;
    chk("rst_mid_out", alu_out, 0);
    chk("rst_mid_ctl", {alu_done, alu_wb, alu_busy}, 0);
    chk("rst_mid_flags", {fl_zero, fl_negative, fl_carry, fl_overflow}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_out", alu_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_alu.md
Name: cpu_alu

Overview:
- Execution unit directly downstream of the control unit.
- Accepts an opcode and two 16-bit operands (term1/term2) on an alu_enable handshake.
- Returns alu_out, status flags and a one-cycle alu_done pulse.
- Logic/add/shift ops take one cycle; MUL/DIV/MOD run iteratively (shift-add / restoring division) over 16 cycles.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.
- OPW, 6, opcode width; must match the control unit's opcode field.

Ports:
- clk  input  1  system clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- opcode  input  OPW  operation select, sampled with alu_enable
- term1  input  WIDTH  operand A, sampled with alu_enable
- term2  input  WIDTH  operand B / shift amount, sampled with alu_enable
- alu_enable  input  1  start request, honoured only while idle
- alu_out  output  WIDTH  result, registered, held until the next completion
- alu_done  output  1  single-cycle completion pulse
- alu_wb  output  1  valid with alu_done; 1 = control unit writes alu_out to acc, 0 = flag-only op
- alu_busy  output  1  high from the acceptance cycle until the done pulse
- fl_zero, fl_negative, fl_carry, fl_overflow  output  1 each  status flags, registered

Behaviour:
- Reset (async, rst_b=0): state=IDLE; alu_out=0, alu_done=0, alu_wb=0, alu_busy=0, all flags=0. An in-flight MUL/DIV is abandoned; no done pulse follows reset release.
- States:
  - IDLE: on alu_enable=1, latch opcode/term1/term2. Go to ITER for MUL/DIV/MOD with nonzero divisor; otherwise go to EXEC.
  - EXEC: compute; go to DONE.
  - ITER: 16-step counter; after step 16, go to DONE.
  - DONE: alu_done=1 for exactly one cycle, with alu_out, alu_wb and flags updated in the same cycle; return to IDLE.
- Latency, counted from the edge that samples alu_enable: single-cycle ops raise done 2 edges later; MUL/DIV/MOD raise done 18 edges later.
- Back-to-back: a new alu_enable is accepted in the cycle after alu_done. alu_enable while busy is ignored; it is neither queued nor an error.
- Opcodes (package constants): ADD 8, SUB 9, LSR 10, LSL 11, RSR 12, RSL 13, MUL 14, DIV 15, MOD 16, AND 17, OR 18, XOR 19, NOT 20, CMP 21, TST 22, INC 23, DEC 24.
- Arithmetic rules:
  - ADD/INC: carry = bit 16 of the sum; overflow = signed overflow.
  - SUB/DEC/CMP: carry = 1 on borrow (term1 < term2 unsigned); overflow = signed overflow.
  - CMP = SUB and TST = AND, both with alu_wb=0; alu_out still takes the computed value.
- Shifts:
  - Amount = term2[3:0]; LSR/LSL fill with 0; RSR/RSL rotate.
  - carry = last bit shifted out; amount 0 gives result = term1 and carry = 0.
- Logic ops (AND/OR/XOR/NOT/TST): carry = 0, overflow = 0.
- MUL: unsigned 16x16. alu_out = low 16 bits; carry = overflow = (high 16 bits != 0).
- DIV/MOD: unsigned. DIV returns the quotient, MOD the remainder; carry = 0, overflow = 0.
- Divide by zero: goes to EXEC and is not iterated. DIV gives 16'hFFFF, MOD gives term1; overflow = 1; done after single-cycle latency.
- fl_zero = (result == 0) and fl_negative = result[15] for every op.
- Unknown opcode: done pulses after single-cycle latency with alu_wb=0; alu_out and flags unchanged.
- Flags and alu_out change only in the DONE cycle; they are stable at all other times.

Decomposition:
- Package cpu_alu_pkg holds:
  - opcode localparams;
  - state encoding (IDLE/EXEC/ITER/DONE);
  - ITER_STEPS=16.
- One sub-module, alu_muldiv_iter: shared 16-step shift-add / restoring-divide engine with start/done, instantiated once. Single-cycle ops stay inline.

Test Plan:
- Reset mid-MUL: start MUL 300*300, pull rst_b low at step 8 -> all outputs 0 immediately; no alu_done after release.
- ADD 0x7FFF + 0x0001 -> alu_out=0x8000, negative=1, overflow=1, carry=0, zero=0, alu_wb=1, done 2 edges after enable.
- SUB 0x0005 - 0x0005 -> 0x0000, zero=1, carry=0. Then CMP 0x0003 vs 0x0004 -> carry=1, negative=1, alu_wb=0.
- MUL 300*300 -> alu_out=0x5F90, carry=1, overflow=1, done exactly 18 edges after enable. A second enable pulsed at step 5 is ignored, so exactly one done.
- DIV 1000/7 -> 0x008E; MOD 1000/7 -> 0x0006 (each 18 edges). DIV 0x1234/0 -> 0xFFFF with overflow=1; MOD 0x1234/0 -> 0x1234 (each 2 edges).
- RSL 0x8001 by 1 -> 0x0003, carry=1. LSR 0x00F0 by 0 -> 0x00F0, carry=0. Opcode 63 -> done with alu_wb=0, outputs unchanged.
